// File: rtl/multi_clock_divider_if.sv
// Configuration bus for multi_clock_divider.
//   cfg_we    : write strobe (master -> slave)
//   cfg_ch    : target channel
//   cfg_div   : half-period D in clock cycles (0 is rejected)
//   cfg_phase : phase delay P in cycles, used at the next restart
//   cfg_err   : one-cycle pulse after a rejected write (slave -> master)
//   pending   : per-channel flag, an accepted divide is waiting to commit
interface multi_clock_divider_if #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 8,
  parameter int CH_W   = 2
);
  logic              cfg_we;
  logic [CH_W-1:0]   cfg_ch;
  logic [CNT_W-1:0]  cfg_div;
  logic [CNT_W-1:0]  cfg_phase;
  logic              cfg_err;
  logic [NUM_CH-1:0] pending;

  modport master (
    output cfg_we, cfg_ch, cfg_div, cfg_phase,
    input  cfg_err, pending
  );

  modport slave (
    input  cfg_we, cfg_ch, cfg_div, cfg_phase,
    output cfg_err, pending
  );
endinterface

// File: rtl/multi_clock_divider.sv
// multi_clock_divider: NUM_CH independent clock dividers with programmable
// half-period and phase offset, glitch-free divide updates and a global
// re-align pulse.
//   clock   : system clock, all logic on its rising edge
//   reset   : synchronous, active-high
//   enable  : 0 freezes every channel (config writes and sync still work)
//   sync    : one-cycle pulse, restarts all channels aligned
//   cfg     : configuration bus (slave side)
//   clk_out : divided clocks, registered, 50% duty
//   tick    : one-cycle pulse in the cycle clk_out[i] first reads 1
module multi_clock_divider #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 8,
  parameter int CH_W   = 2
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 sync,
  multi_clock_divider_if.slave cfg,
  output logic [NUM_CH-1:0]    clk_out,
  output logic [NUM_CH-1:0]    tick
);

  typedef enum logic {ST_WAIT, ST_RUN} state_e;

  // d is the active half-period, ds the shadow awaiting commit, p the
  // programmed phase and p_act the phase latched at the last restart.
  typedef struct packed {
    state_e           st;
    logic [CNT_W-1:0] d;
    logic [CNT_W-1:0] ds;
    logic [CNT_W-1:0] p;
    logic [CNT_W-1:0] p_act;
    logic [CNT_W-1:0] cnt;
    logic             clk;
    logic             tick;
    logic             pend;
  } ch_t;

  ch_t               ch_q [NUM_CH];
  ch_t               ch_n [NUM_CH];
  logic              cfg_ok;
  logic [NUM_CH-1:0] wr_hit;
  logic              cfg_err_q;

  // Write decode: a write is accepted only for a real channel and D >= 1.
  always_comb begin
    cfg_ok = (cfg.cfg_div != '0) && (int'(cfg.cfg_ch) < NUM_CH);
    wr_hit = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      wr_hit[i] = cfg.cfg_we && cfg_ok && (int'(cfg.cfg_ch) == i);
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      // NOTE: every field starts from its held value so no path leaves it
      // unassigned; that is what keeps this block free of latches.
      ch_n[i]      = ch_q[i];
      ch_n[i].tick = 1'b0;

      // A running, enabled channel defers the divide to the next falling
      // toggle; otherwise (WAIT, frozen, or restarting) it loads at once.
      if (wr_hit[i]) begin
        ch_n[i].p = cfg.cfg_phase;
        if (ch_q[i].st == ST_RUN && enable && !sync) begin
          ch_n[i].ds   = cfg.cfg_div;
          ch_n[i].pend = 1'b1;
        end else begin
          ch_n[i].d    = cfg.cfg_div;
          ch_n[i].ds   = cfg.cfg_div;
          ch_n[i].pend = 1'b0;
        end
      end

      if (sync) begin
        if (ch_n[i].pend) ch_n[i].d = ch_n[i].ds;
        ch_n[i].pend  = 1'b0;
        ch_n[i].cnt   = '0;
        ch_n[i].clk   = 1'b0;
        ch_n[i].st    = ST_WAIT;
        ch_n[i].p_act = ch_n[i].p;
      end else if (enable) begin
        unique case (ch_q[i].st)
          ST_WAIT: begin
            if (ch_q[i].cnt == ch_q[i].p_act) begin
              ch_n[i].st  = ST_RUN;
              ch_n[i].cnt = '0;
            end else begin
              ch_n[i].cnt = ch_q[i].cnt + 1'b1;
            end
          end
          ST_RUN: begin
            if (ch_q[i].cnt == ch_q[i].d - 1'b1) begin
              ch_n[i].cnt = '0;
              ch_n[i].clk = ~ch_q[i].clk;
              if (!ch_q[i].clk) begin
                ch_n[i].tick = 1'b1;
              end else if (ch_q[i].pend) begin
                // Commit only on the falling toggle so the high phase that
                // just ended used the old D and the next period uses the new.
                ch_n[i].d = ch_q[i].ds;
                if (!wr_hit[i]) ch_n[i].pend = 1'b0;
              end
            end else begin
              ch_n[i].cnt = ch_q[i].cnt + 1'b1;
            end
          end
          default: ch_n[i].st = ST_WAIT;
        endcase
      end
    end
  end

  // NOTE: the per-channel register array is small control state, not a
  // RAM, so every entry is reset to a known divide and phase.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++) begin
        ch_q[i] <= '{st: ST_WAIT, d: CNT_W'(1), ds: CNT_W'(1), p: '0,
                     p_act: '0, cnt: '0, clk: 1'b0, tick: 1'b0, pend: 1'b0};
      end
      cfg_err_q <= 1'b0;
    end else begin
      // NOTE: non-blocking so every channel samples the pre-edge state.
      for (int i = 0; i < NUM_CH; i++) begin
        ch_q[i] <= ch_n[i];
      end
      cfg_err_q <= cfg.cfg_we && !cfg_ok;
    end
  end

  always_comb begin
    clk_out     = '0;
    tick        = '0;
    cfg.pending = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      clk_out[i]     = ch_q[i].clk;
      tick[i]        = ch_q[i].tick;
      cfg.pending[i] = ch_q[i].pend;
    end
  end

  assign cfg.cfg_err = cfg_err_q;

endmodule
